// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: 2-flop synchronizer, persistence-count
// debounce and registered rise/fall pulses for each channel independently.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:1] btn_raw,
    output logic [3:1] b,
    output logic [3:1] b_rise,
    output logic [3:1] b_fall
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 1; g <= 3; g++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          level;
        logic          rise;
        logic          fall;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= btn_raw[g];
                sync2 <= sync1;
                rise  <= 1'b0;
                fall  <= 1'b0;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    // Deviation persisted long enough: accept it and pulse once.
                    level <= sync2;
                    rise  <= sync2;
                    fall  <= ~sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign b[g]      = level;
        assign b_rise[g] = rise;
        assign b_fall[g] = fall;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// all checked against a run-length reference model of the debounce rules.
module tb_button_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:1] btn_raw = 3'b000;
    logic [3:1] b;
    logic [3:1] b_rise;
    logic [3:1] b_fall;

    int checks = 0;
    int errors = 0;

    // Reference model: raw samples delayed two edges, then a per-channel count of
    // consecutive mismatching cycles; DC mismatches in a row flip the level.
    logic [3:1] hist[$];
    logic [3:1] m_b;
    logic [3:1] m_rise;
    logic [3:1] m_fall;
    int         run[1:3];

    button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .b      (b),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        hist = '{3'b000, 3'b000};
        m_b = 3'b000;
        m_rise = 3'b000;
        m_fall = 3'b000;
        for (int i = 1; i <= 3; i++) run[i] = 0;
    endtask

    task automatic tick();
        logic [3:1] s2;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            s2 = hist[0];
            m_rise = 3'b000;
            m_fall = 3'b000;
            for (int i = 1; i <= 3; i++) begin
                if (s2[i] != m_b[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DC) begin
                        m_b[i] = s2[i];
                        if (s2[i]) m_rise[i] = 1'b1;
                        else m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            void'(hist.pop_front());
            hist.push_back(btn_raw);
        end
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({b, b_rise, b_fall} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got b=%b rise=%b fall=%b want all 000", b, b_rise, b_fall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        btn_raw = 3'b111;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (b !== m_b || b_rise !== m_rise || b_fall !== m_fall) begin
                errors++;
                $display("FAIL reset_pre cyc%0d: got b=%b r=%b f=%b want b=%b r=%b f=%b",
                         k, b, b_rise, b_fall, m_b, m_rise, m_fall);
            end
        end
        checks++;
        if (b !== 3'b111) begin
            errors++;
            $display("FAIL reset_pre_level: got b=%b want 111", b);
        end
        // Assert reset mid-cycle, well clear of any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (b !== 3'b000 || b_rise !== 3'b000 || b_fall !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: got b=%b r=%b f=%b want 000 000 000", b, b_rise, b_fall);
        end
        btn_raw = 3'b000;
        tick();
        tick();
        checks++;
        if ({b, b_rise, b_fall} !== 9'b0) begin
            errors++;
            $display("FAIL reset_hold: got b=%b r=%b f=%b want all 000", b, b_rise, b_fall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (b[1] !== (k >= 6) || b_rise[1] !== (k == 6) || b_fall[1] !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge%0d: got b1=%b r1=%b f1=%b want b1=%b r1=%b f1=0",
                         k, b[1], b_rise[1], b_fall[1], (k >= 6), (k == 6));
            end
            checks++;
            if (b !== m_b || b_rise !== m_rise || b_fall !== m_fall) begin
                errors++;
                $display("FAIL clean_press_model edge%0d: got b=%b r=%b f=%b want b=%b r=%b f=%b",
                         k, b, b_rise, b_fall, m_b, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_glitch();
        btn_raw[2] = 1'b1;
        tick();
        tick();
        tick();
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (b[2] !== 1'b0 || b_rise[2] !== 1'b0 || b_fall[2] !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge%0d: got b2=%b r2=%b f2=%b want 0 0 0",
                         k, b[2], b_rise[2], b_fall[2]);
            end
        end
        // A full press afterwards must need the full count, proving the count cleared.
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (b[2] !== (k >= 6) || b_rise[2] !== (k == 6)) begin
                errors++;
                $display("FAIL glitch_recount edge%0d: got b2=%b r2=%b want b2=%b r2=%b",
                         k, b[2], b_rise[2], (k >= 6), (k == 6));
            end
        end
    endtask

    task automatic test_release();
        btn_raw[3] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (b[3] !== 1'b1) begin
            errors++;
            $display("FAIL release_setup: got b3=%b want 1", b[3]);
        end
        btn_raw[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (b[3] !== (k < 6) || b_fall[3] !== (k == 6) || b_rise[3] !== 1'b0) begin
                errors++;
                $display("FAIL release edge%0d: got b3=%b f3=%b r3=%b want b3=%b f3=%b r3=0",
                         k, b[3], b_fall[3], b_rise[3], (k < 6), (k == 6));
            end
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 3'b000;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (b !== 3'b000) begin
            errors++;
            $display("FAIL simul_setup: got b=%b want 000", b);
        end
        btn_raw = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (b !== ((k >= 6) ? 3'b101 : 3'b000) || b_rise !== ((k == 6) ? 3'b101 : 3'b000)
                || b_fall !== 3'b000) begin
                errors++;
                $display("FAIL simultaneous edge%0d: got b=%b r=%b f=%b want b=%b r=%b f=000",
                         k, b, b_rise, b_fall, (k >= 6) ? 3'b101 : 3'b000,
                         (k == 6) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_raw = 3'b000;
        for (int k = 0; k < 10; k++) tick();
        btn_raw[1] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({b, b_rise, b_fall} !== 9'b0) begin
                errors++;
                $display("FAIL reset_mid_hold edge%0d: got b=%b r=%b f=%b want all 000",
                         k, b, b_rise, b_fall);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (b[1] !== (k >= 6) || b_rise[1] !== (k == 6) || b_fall !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_after edge%0d: got b1=%b r1=%b f=%b want b1=%b r1=%b f=000",
                         k, b[1], b_rise[1], b_fall, (k >= 6), (k == 6));
            end
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 600) begin
            int hold;
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 3) != 0) btn_raw = 3'($urandom_range(0, 7));
            for (int k = 0; k < hold; k++) begin
                tick();
                cyc++;
                checks++;
                if (b !== m_b || b_rise !== m_rise || b_fall !== m_fall) begin
                    errors++;
                    $display("FAIL random cyc%0d: got b=%b r=%b f=%b want b=%b r=%b f=%b",
                             cyc, b, b_rise, b_fall, m_b, m_rise, m_fall);
                end
                checks++;
                if ((b_rise & b_fall) !== 3'b000) begin
                    errors++;
                    $display("FAIL random_excl cyc%0d: got rise&fall=%b want 000",
                             cyc, b_rise & b_fall);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
